// File: rtl/pipelined_mem_server.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_mem_server
// Purpose  : Single-port 32-bit memory that serves valid/ready requests
//            through a fixed-latency, valid-tagged shift pipeline. The
//            pipeline drains into a response FIFO. Responses leave in
//            request order.
// Ports    : clk, rst                 - clock and async active-high reset
//            req_val / req_rdy        - request handshake
//            req_msg_{op,opaque,addr,strb,data}  - request payload
//            resp_val / resp_rdy      - response handshake
//            resp_msg_{op,opaque,addr,strb,data} - response payload
//                                       (FIFO head)
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_mem_server #(
    parameter int p_opaq_bits  = 8,
    parameter int p_num_words  = 256,
    parameter int p_latency    = 2,
    parameter int p_resp_depth = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_val,
    output logic                   req_rdy,
    input  logic                   req_msg_op,
    input  logic [p_opaq_bits-1:0] req_msg_opaque,
    input  logic [31:0]            req_msg_addr,
    input  logic [3:0]             req_msg_strb,
    input  logic [31:0]            req_msg_data,
    output logic                   resp_val,
    input  logic                   resp_rdy,
    output logic                   resp_msg_op,
    output logic [p_opaq_bits-1:0] resp_msg_opaque,
    output logic [31:0]            resp_msg_addr,
    output logic [3:0]             resp_msg_strb,
    output logic [31:0]            resp_msg_data
);

    localparam logic c_op_write = 1'b1;  // op 0 is read
    localparam int   c_idx_bits = $clog2(p_num_words);
    localparam int   c_cnt_bits = $clog2(p_resp_depth + 1);
    localparam int   c_ptr_bits = (p_resp_depth > 1) ? $clog2(p_resp_depth) : 1;

    localparam logic [c_cnt_bits-1:0] c_cnt_one  = c_cnt_bits'(1);
    localparam logic [c_cnt_bits-1:0] c_cnt_max  = c_cnt_bits'(p_resp_depth);
    localparam logic [c_ptr_bits-1:0] c_ptr_one  = c_ptr_bits'(1);
    localparam logic [c_ptr_bits-1:0] c_ptr_last = c_ptr_bits'(p_resp_depth - 1);

    typedef struct packed {
        logic                   op;
        logic [p_opaq_bits-1:0] opaque;
        logic [31:0]            addr;
        logic [3:0]             strb;
        logic [31:0]            data;
    } msg_t;

    // ------------------------------------------------------------------
    // Request side: array access happens at the accept edge
    // ------------------------------------------------------------------
    logic [31:0]           mem_q [p_num_words];
    logic                  w_req_xfer;
    logic                  w_resp_xfer;
    logic                  w_is_write;
    logic [c_idx_bits-1:0] w_idx;
    logic [31:0]           w_rd_word;
    logic [31:0]           w_wr_word;
    msg_t                  w_req_pkt;

    always_comb begin
        w_req_xfer  = req_val & req_rdy;
        w_resp_xfer = resp_val & resp_rdy;
        w_is_write  = (req_msg_op == c_op_write);
        w_idx       = req_msg_addr[c_idx_bits+1:2];
        w_rd_word   = mem_q[w_idx];
        // Byte merge: unstrobed lanes keep the stored value
        w_wr_word   = w_rd_word;
        for (int b = 0; b < 4; b++) begin
            if (req_msg_strb[b]) begin
                w_wr_word[8*b +: 8] = req_msg_data[8*b +: 8];
            end
        end
        w_req_pkt.op     = req_msg_op;
        w_req_pkt.opaque = req_msg_opaque;
        w_req_pkt.addr   = req_msg_addr;
        w_req_pkt.strb   = req_msg_strb;
        w_req_pkt.data   = w_is_write ? 32'h0 : w_rd_word;
    end

    // Array contents survive reset
    always_ff @(posedge clk) begin
        if (w_req_xfer && w_is_write) begin
            mem_q[w_idx] <= w_wr_word;
        end
    end

    // ------------------------------------------------------------------
    // Latency pipeline. The accept cycle counts as the first stage, so
    // p_latency-1 registered stages plus the FIFO write give a response
    // p_latency cycles after accept when the FIFO is empty.
    // ------------------------------------------------------------------
    logic w_push_vld;
    msg_t w_push_msg;

    generate
        if (p_latency == 1) begin : g_direct
            assign w_push_vld = w_req_xfer;
            assign w_push_msg = w_req_pkt;
        end else begin : g_pipe
            logic [p_latency-2:0] vld_q;
            logic [p_latency-2:0] vld_d;
            msg_t                 pay_q [p_latency-1];
            msg_t                 pay_d [p_latency-1];

            always_comb begin
                vld_d    = '0;
                vld_d[0] = w_req_xfer;
                pay_d[0] = w_req_pkt;
                for (int i = 1; i < p_latency - 1; i++) begin
                    vld_d[i] = vld_q[i-1];
                    pay_d[i] = pay_q[i-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= '0;
                end else begin
                    vld_q <= vld_d;
                end
            end

            always_ff @(posedge clk) begin
                pay_q <= pay_d;
            end

            assign w_push_vld = vld_q[p_latency-2];
            assign w_push_msg = pay_q[p_latency-2];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Response FIFO and in-flight accounting. The in-flight counter also
    // covers pipeline occupancy, so a push can never find the FIFO full
    // without a pop on the same edge.
    // ------------------------------------------------------------------
    msg_t                  fifo_q [p_resp_depth];
    logic [c_ptr_bits-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_bits-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_bits-1:0] fcnt_q, fcnt_d;
    logic [c_cnt_bits-1:0] inflight_q, inflight_d;
    msg_t                  w_head;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fcnt_d     = fcnt_q;
        inflight_d = inflight_q;

        if (w_push_vld) begin
            wr_ptr_d = (wr_ptr_q == c_ptr_last) ? '0 : wr_ptr_q + c_ptr_one;
        end
        if (w_resp_xfer) begin
            rd_ptr_d = (rd_ptr_q == c_ptr_last) ? '0 : rd_ptr_q + c_ptr_one;
        end

        case ({w_push_vld, w_resp_xfer})
            2'b10:   fcnt_d = fcnt_q + c_cnt_one;
            2'b01:   fcnt_d = fcnt_q - c_cnt_one;
            default: fcnt_d = fcnt_q;
        endcase

        case ({w_req_xfer, w_resp_xfer})
            2'b10:   inflight_d = inflight_q + c_cnt_one;
            2'b01:   inflight_d = inflight_q - c_cnt_one;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fcnt_q     <= '0;
            inflight_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fcnt_q     <= fcnt_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_vld) begin
            fifo_q[wr_ptr_q] <= w_push_msg;
        end
    end

    assign w_head          = fifo_q[rd_ptr_q];
    assign req_rdy         = (inflight_q < c_cnt_max);
    assign resp_val        = (fcnt_q != '0);
    assign resp_msg_op     = w_head.op;
    assign resp_msg_opaque = w_head.opaque;
    assign resp_msg_addr   = w_head.addr;
    assign resp_msg_strb   = w_head.strb;
    assign resp_msg_data   = w_head.data;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_mem_server.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_mem_server
// Purpose  : Directed and randomized self-checking bench for
//            pipelined_mem_server at default parameters (latency 2,
//            FIFO depth 4, 256 words, 8-bit opaque). Inputs change 1 time
//            unit after each rising edge; outputs are sampled there too.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_mem_server;

    localparam int   OPQ   = 8;
    localparam int   DEPTH = 4;
    localparam logic RD    = 1'b0;
    localparam logic WR    = 1'b1;

    logic           clk;
    logic           rst;
    logic           req_val;
    logic           req_rdy;
    logic           req_msg_op;
    logic [OPQ-1:0] req_msg_opaque;
    logic [31:0]    req_msg_addr;
    logic [3:0]     req_msg_strb;
    logic [31:0]    req_msg_data;
    logic           resp_val;
    logic           resp_rdy;
    logic           resp_msg_op;
    logic [OPQ-1:0] resp_msg_opaque;
    logic [31:0]    resp_msg_addr;
    logic [3:0]     resp_msg_strb;
    logic [31:0]    resp_msg_data;

    pipelined_mem_server #(
        .p_opaq_bits  (OPQ),
        .p_num_words  (256),
        .p_latency    (2),
        .p_resp_depth (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_val         (req_val),
        .req_rdy         (req_rdy),
        .req_msg_op      (req_msg_op),
        .req_msg_opaque  (req_msg_opaque),
        .req_msg_addr    (req_msg_addr),
        .req_msg_strb    (req_msg_strb),
        .req_msg_data    (req_msg_data),
        .resp_val        (resp_val),
        .resp_rdy        (resp_rdy),
        .resp_msg_op     (resp_msg_op),
        .resp_msg_opaque (resp_msg_opaque),
        .resp_msg_addr   (resp_msg_addr),
        .resp_msg_strb   (resp_msg_strb),
        .resp_msg_data   (resp_msg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_asrt = 0;
    int n_fail = 0;

    // Random-phase reference state
    logic [31:0] ref_mem [16];
    logic [79:0] exp_q [$];
    logic [79:0] exp_item;
    logic [31:0] ref_word;
    int          ref_idx;
    int          n_acc;
    int          cyc;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic op, input logic [7:0] opq, input logic [31:0] addr,
                           input logic [3:0] strb, input logic [31:0] data);
        req_val        = 1'b1;
        req_msg_op     = op;
        req_msg_opaque = opq;
        req_msg_addr   = addr;
        req_msg_strb   = strb;
        req_msg_data   = data;
    endtask

    function automatic logic [79:0] pack(input logic op, input logic [7:0] opq,
                                         input logic [31:0] addr, input logic [3:0] strb,
                                         input logic [31:0] data);
        return {3'b0, op, opq, addr, strb, data};
    endfunction

    function automatic logic [79:0] got();
        return pack(resp_msg_op, resp_msg_opaque, resp_msg_addr, resp_msg_strb, resp_msg_data);
    endfunction

    initial begin
        rst            = 1'b1;
        req_val        = 1'b0;
        req_msg_op     = RD;
        req_msg_opaque = '0;
        req_msg_addr   = '0;
        req_msg_strb   = '0;
        req_msg_data   = '0;
        resp_rdy       = 1'b0;

        // ---------------- reset state ----------------
        #12;
        chk("rst_req_rdy", req_rdy, 1);
        chk("rst_resp_val", resp_val, 0);
        #1 rst = 1'b0;
        tick();
        chk("post_rst_req_rdy", req_rdy, 1);
        chk("post_rst_resp_val", resp_val, 0);

        // ---------------- full write then read, latency 2 ----------------
        resp_rdy = 1'b1;
        set_req(WR, 8'h11, 32'h10, 4'hF, 32'hDEADBEEF);
        tick();
        set_req(RD, 8'h12, 32'h10, 4'h0, 32'h0);
        chk("lat_not_early", resp_val, 0);
        tick();
        req_val = 1'b0;
        chk("wr_resp_val", resp_val, 1);
        chk("wr_resp", got(), pack(WR, 8'h11, 32'h10, 4'hF, 32'h0));
        tick();
        chk("rd_resp_val", resp_val, 1);
        chk("rd_resp", got(), pack(RD, 8'h12, 32'h10, 4'h0, 32'hDEADBEEF));
        tick();
        chk("t1_drained", resp_val, 0);

        // ---------------- byte strobe merge ----------------
        set_req(WR, 8'h21, 32'h20, 4'hF, 32'h11223344);
        tick();
        set_req(WR, 8'h22, 32'h20, 4'h4, 32'hAABBCCDD);
        tick();
        set_req(RD, 8'h23, 32'h22, 4'h0, 32'h0);
        tick();
        req_val = 1'b0;
        tick();
        chk("strb_merge_rd", got(), pack(RD, 8'h23, 32'h22, 4'h0, 32'h11BB3344));
        tick();
        tick();
        chk("t2_drained", resp_val, 0);

        // ---------------- backpressure: fill 4, pop one ----------------
        resp_rdy = 1'b0;
        set_req(RD, 8'h31, 32'h10, 4'h0, 32'h0);
        tick();
        set_req(RD, 8'h32, 32'h20, 4'h0, 32'h0);
        tick();
        set_req(RD, 8'h33, 32'h11, 4'h0, 32'h0);
        tick();
        chk("bp_rdy_after3", req_rdy, 1);
        set_req(RD, 8'h34, 32'h23, 4'h0, 32'h0);
        tick();
        req_val = 1'b0;
        chk("bp_rdy_after4", req_rdy, 0);
        chk("bp_head0", got(), pack(RD, 8'h31, 32'h10, 4'h0, 32'hDEADBEEF));
        tick();
        tick();
        chk("bp_hold_val", resp_val, 1);
        chk("bp_hold_head", got(), pack(RD, 8'h31, 32'h10, 4'h0, 32'hDEADBEEF));
        chk("bp_still_full", req_rdy, 0);
        resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
        chk("bp_rdy_after_pop", req_rdy, 1);
        chk("bp_head1", got(), pack(RD, 8'h32, 32'h20, 4'h0, 32'h11BB3344));
        tick();
        chk("bp_head1_hold", got(), pack(RD, 8'h32, 32'h20, 4'h0, 32'h11BB3344));
        resp_rdy = 1'b1;
        tick();
        chk("bp_head2", got(), pack(RD, 8'h33, 32'h11, 4'h0, 32'hDEADBEEF));
        tick();
        chk("bp_head3", got(), pack(RD, 8'h34, 32'h23, 4'h0, 32'h11BB3344));
        tick();
        chk("bp_drained", resp_val, 0);

        // ---------------- address aliasing ----------------
        set_req(WR, 8'h41, 32'h400, 4'hF, 32'h5);
        tick();
        set_req(RD, 8'h42, 32'h0, 4'h0, 32'h0);
        tick();
        req_val = 1'b0;
        chk("alias_wr", got(), pack(WR, 8'h41, 32'h400, 4'hF, 32'h0));
        tick();
        chk("alias_rd", got(), pack(RD, 8'h42, 32'h0, 4'h0, 32'h5));
        tick();

        // ---------------- asynchronous reset mid-flight ----------------
        resp_rdy = 1'b0;
        set_req(RD, 8'h51, 32'h10, 4'h0, 32'h0);
        tick();
        set_req(RD, 8'h52, 32'h10, 4'h0, 32'h0);
        tick();
        set_req(RD, 8'h53, 32'h10, 4'h0, 32'h0);
        tick();
        req_val = 1'b0;
        chk("pre_rst_val", resp_val, 1);
        chk("pre_rst_rdy", req_rdy, 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_resp_val", resp_val, 0);
        chk("arst_req_rdy", req_rdy, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        resp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_stale_resp", resp_val, 0);
            chk("post_arst_rdy", req_rdy, 1);
        end
        set_req(RD, 8'h61, 32'h0, 4'h0, 32'h0);
        tick();
        req_val = 1'b0;
        tick();
        chk("mem_kept_on_rst", got(), pack(RD, 8'h61, 32'h0, 4'h0, 32'h5));
        tick();

        // ---------------- random traffic against reference model ----------------
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 1000 && cyc < 20000) begin
            req_val  = ($urandom_range(0, 3) != 0);
            resp_rdy = ($urandom_range(0, 2) != 0);
            if (n_acc < 16) begin
                req_msg_op   = WR;
                req_msg_addr = 32'(n_acc) << 2;
                req_msg_strb = 4'hF;
            end else begin
                req_msg_op   = 1'($urandom_range(0, 1));
                req_msg_addr = $urandom & 32'hFFFF_FC3F;
                req_msg_strb = 4'($urandom_range(0, 15));
            end
            req_msg_opaque = 8'($urandom_range(0, 255));
            req_msg_data   = $urandom;

            chk("rnd_req_rdy", req_rdy, (exp_q.size() < DEPTH));
            chk("rnd_resp_without_req", (resp_val && exp_q.size() == 0), 0);
            if (resp_val && resp_rdy && exp_q.size() != 0) begin
                exp_item = exp_q.pop_front();
                chk("rnd_resp", got(), exp_item);
            end
            if (req_val && req_rdy) begin
                ref_idx  = int'(req_msg_addr[5:2]);
                ref_word = ref_mem[ref_idx];
                if (req_msg_op == WR) begin
                    for (int b = 0; b < 4; b++) begin
                        if (req_msg_strb[b]) ref_mem[ref_idx][8*b +: 8] = req_msg_data[8*b +: 8];
                    end
                    exp_q.push_back(pack(WR, req_msg_opaque, req_msg_addr, req_msg_strb, 32'h0));
                end else begin
                    exp_q.push_back(pack(RD, req_msg_opaque, req_msg_addr, req_msg_strb, ref_word));
                end
                n_acc++;
            end
            tick();
            cyc++;
        end
        chk("rnd_ops_done", (n_acc >= 1000), 1);

        req_val  = 1'b0;
        resp_rdy = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            if (resp_val) begin
                exp_item = exp_q.pop_front();
                chk("drain_resp", got(), exp_item);
            end
            tick();
        end
        chk("drain_all_delivered", exp_q.size(), 0);
        chk("drain_resp_val", resp_val, 0);
        chk("drain_req_rdy", req_rdy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
